// File: rtl/caxi4interconnect_dwc_upconv_rchan_extractor_pkg.sv
// Shared decode types and address arithmetic for the up-converting DWC.
// The byte-width constants describe the default 32/64 configuration.
package caxi4interconnect_dwc_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } dwc_state_e;

   localparam int IB         = 4;
   localparam int OB         = 8;
   localparam int LANE_IDX_W = $clog2(OB) - $clog2(IB);

   // Address of the next master beat; all arithmetic wraps at 64 bytes.
   function automatic logic [5:0] dwc_next_addr(
      input logic [5:0] addr,
      input logic [2:0] size,
      input logic [7:0] len,
      input logic       fixed,
      input logic       wrap
   );
      logic [5:0]  incr;
      logic [15:0] span;
      logic [5:0]  wmask;
      logic [5:0]  nxt;
      incr  = 6'(7'd1 << size);
      span  = (16'(len) + 16'd1) << size;
      wmask = 6'(span - 16'd1);
      if (fixed) begin
         nxt = addr;
      end else if (wrap) begin
         nxt = (addr & ~wmask) | ((addr + incr) & wmask);
      end else begin
         nxt = (addr & ~(incr - 6'd1)) + incr;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/caxi4interconnect_dwc_upconv_rchan_extractor_if.sv
// Command-FIFO, wide slave R channel and narrow master R channel bundle.
// The slave modport is the extractor's view; master is the surrounding fabric.
interface caxi4interconnect_dwc_upconv_rchan_extractor_if #(
   parameter int DATA_WIDTH_IN  = 32,
   parameter int DATA_WIDTH_OUT = 64,
   parameter int ID_WIDTH       = 4,
   parameter int USER_WIDTH     = 1
);
   logic                      cmd_fifo_empty;
   logic                      cmd_fifo_rd_en;
   logic [5:0]                cmd_addr;
   logic [2:0]                cmd_size;
   logic [7:0]                cmd_len;
   logic                      cmd_fixed;
   logic                      cmd_wrap;
   logic [DATA_WIDTH_OUT-1:0] s_rdata;
   logic [ID_WIDTH-1:0]       s_rid;
   logic [1:0]                s_rresp;
   logic [USER_WIDTH-1:0]     s_ruser;
   logic                      s_rlast;
   logic                      s_rvalid;
   logic                      s_rready;
   logic [DATA_WIDTH_IN-1:0]  m_rdata;
   logic [ID_WIDTH-1:0]       m_rid;
   logic [1:0]                m_rresp;
   logic [USER_WIDTH-1:0]     m_ruser;
   logic                      m_rlast;
   logic                      m_rvalid;
   logic                      m_rready;
   logic                      err_early_last;

   modport slave (
      input  cmd_fifo_empty, cmd_addr, cmd_size, cmd_len, cmd_fixed, cmd_wrap,
      input  s_rdata, s_rid, s_rresp, s_ruser, s_rlast, s_rvalid, m_rready,
      output cmd_fifo_rd_en, s_rready,
      output m_rdata, m_rid, m_rresp, m_ruser, m_rlast, m_rvalid, err_early_last
   );

   modport master (
      output cmd_fifo_empty, cmd_addr, cmd_size, cmd_len, cmd_fixed, cmd_wrap,
      output s_rdata, s_rid, s_rresp, s_ruser, s_rlast, s_rvalid, m_rready,
      input  cmd_fifo_rd_en, s_rready,
      input  m_rdata, m_rid, m_rresp, m_ruser, m_rlast, m_rvalid, err_early_last
   );
endinterface

// File: rtl/caxi4interconnect_dwc_upconv_rchan_extractor_addr_gen.sv
// Next-beat address, byte-lane index and wide-beat pop decision.
// Purely combinational so the write-side packer can reuse it.
module caxi4interconnect_dwc_rchan_addr_gen
   import caxi4interconnect_dwc_pkg::*;
#(
   parameter int OB_LOG2 = $clog2(OB),
   parameter int IB_LOG2 = $clog2(OB) - LANE_IDX_W
) (
   input  logic [5:0]                 i_cur_addr,
   input  logic [2:0]                 i_size,
   input  logic [7:0]                 i_len,
   input  logic [7:0]                 i_remaining,
   input  logic                       i_fixed,
   input  logic                       i_wrap,
   output logic [5:0]                 o_next_addr,
   output logic [OB_LOG2-IB_LOG2-1:0] o_lane,
   output logic                       o_pop
);
   localparam logic [5:0] OFF_MASK = 6'((7'd1 << OB_LOG2) - 7'd1);

   logic [5:0] w_next;
   logic [5:0] w_cur_off;
   logic [5:0] w_next_off;

   // A wide beat is released when the next narrow beat leaves it or wraps back inside it.
   always_comb begin
      w_next      = dwc_next_addr(i_cur_addr, i_size, i_len, i_fixed, i_wrap);
      w_cur_off   = i_cur_addr & OFF_MASK;
      w_next_off  = w_next & OFF_MASK;
      o_next_addr = w_next;
      o_lane      = (OB_LOG2-IB_LOG2)'(w_cur_off >> IB_LOG2);
      o_pop       = (i_remaining == 8'd0) || i_fixed ||
                    ((w_next >> OB_LOG2) != (i_cur_addr >> OB_LOG2)) ||
                    (w_next_off <= w_cur_off);
   end

endmodule

// File: rtl/caxi4interconnect_dwc_upconv_rchan_extractor.sv
// Splits wide R beats into narrow master beats using the per-burst command.
// m_rlast is derived from the beat counter; an early s_rlast is only flagged.
module caxi4interconnect_dwc_upconv_rchan_extractor
   import caxi4interconnect_dwc_pkg::*;
#(
   parameter int DATA_WIDTH_IN  = IB * 8,
   parameter int DATA_WIDTH_OUT = OB * 8,
   parameter int ID_WIDTH       = 4,
   parameter int USER_WIDTH     = 1
) (
   input  logic clk,
   input  logic rst,
   caxi4interconnect_dwc_upconv_rchan_extractor_if.slave bus
);
   localparam int IB_LOG2 = $clog2(DATA_WIDTH_IN / 8);
   localparam int OB_LOG2 = $clog2(DATA_WIDTH_OUT / 8);
   localparam int LANE_W  = OB_LOG2 - IB_LOG2;

   dwc_state_e                r_state;
   logic [5:0]                r_cur_addr;
   logic [2:0]                r_size;
   logic [7:0]                r_len;
   logic [7:0]                r_remaining;
   logic                      r_fixed;
   logic                      r_wrap;
   logic [DATA_WIDTH_IN-1:0]  r_m_rdata;
   logic [ID_WIDTH-1:0]       r_m_rid;
   logic [1:0]                r_m_rresp;
   logic [USER_WIDTH-1:0]     r_m_ruser;
   logic                      r_m_rlast;
   logic                      r_m_rvalid;
   logic                      r_err_early_last;

   logic [5:0]                w_next_addr;
   logic [LANE_W-1:0]         w_lane;
   logic                      w_pop;
   logic                      w_cmd_pop;
   logic                      w_load;
   logic                      w_s_pop;

   caxi4interconnect_dwc_rchan_addr_gen #(
      .OB_LOG2 (OB_LOG2),
      .IB_LOG2 (IB_LOG2)
   ) u_addr_gen (
      .i_cur_addr  (r_cur_addr),
      .i_size      (r_size),
      .i_len       (r_len),
      .i_remaining (r_remaining),
      .i_fixed     (r_fixed),
      .i_wrap      (r_wrap),
      .o_next_addr (w_next_addr),
      .o_lane      (w_lane),
      .o_pop       (w_pop)
   );

   // Handshake decode; gated by rst so every output reads 0 while reset is held.
   always_comb begin
      w_cmd_pop = !rst && (r_state == ST_IDLE) && !bus.cmd_fifo_empty;
      w_load    = !rst && (r_state == ST_ACTIVE) && bus.s_rvalid &&
                  (!r_m_rvalid || bus.m_rready);
      w_s_pop   = w_load && w_pop;
   end

   // Burst sequencing: command capture, address walk and beat countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cur_addr  <= 6'd0;
         r_size      <= 3'd0;
         r_len       <= 8'd0;
         r_remaining <= 8'd0;
         r_fixed     <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_pop) begin
                  r_cur_addr  <= bus.cmd_addr;
                  r_size      <= bus.cmd_size;
                  r_len       <= bus.cmd_len;
                  r_remaining <= bus.cmd_len;
                  r_fixed     <= bus.cmd_fixed;
                  r_wrap      <= bus.cmd_wrap;
                  r_state     <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (w_load) begin
                  r_cur_addr  <= w_next_addr;
                  r_remaining <= r_remaining - 8'd1;
                  if (r_remaining == 8'd0) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Narrow output register plus the sticky early-last flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_rdata        <= '0;
         r_m_rid          <= '0;
         r_m_rresp        <= 2'd0;
         r_m_ruser        <= '0;
         r_m_rlast        <= 1'b0;
         r_m_rvalid       <= 1'b0;
         r_err_early_last <= 1'b0;
      end else begin
         if (w_load) begin
            r_m_rdata  <= bus.s_rdata[w_lane*DATA_WIDTH_IN +: DATA_WIDTH_IN];
            r_m_rid    <= bus.s_rid;
            r_m_rresp  <= bus.s_rresp;
            r_m_ruser  <= bus.s_ruser;
            r_m_rlast  <= (r_remaining == 8'd0);
            r_m_rvalid <= 1'b1;
         end else if (bus.m_rready) begin
            r_m_rvalid <= 1'b0;
         end
         if (w_s_pop && bus.s_rlast && (r_remaining != 8'd0)) begin
            r_err_early_last <= 1'b1;
         end
      end
   end

   assign bus.cmd_fifo_rd_en = w_cmd_pop;
   assign bus.s_rready       = w_s_pop;
   assign bus.m_rdata        = r_m_rdata;
   assign bus.m_rid          = r_m_rid;
   assign bus.m_rresp        = r_m_rresp;
   assign bus.m_ruser        = r_m_ruser;
   assign bus.m_rlast        = r_m_rlast;
   assign bus.m_rvalid       = r_m_rvalid;
   assign bus.err_early_last = r_err_early_last;

endmodule

// File: tb/tb_caxi4interconnect_dwc_upconv_rchan_extractor.sv
// Directed and randomized bursts against an address-sequence reference model.
module tb_caxi4interconnect_dwc_upconv_rchan_extractor;

   localparam int DWI = 32;
   localparam int DWO = 64;
   localparam int IDW = 4;
   localparam int UW  = 1;
   localparam int IBY = DWI / 8;
   localparam int OBY = DWO / 8;

   typedef struct packed {
      logic [5:0] addr;
      logic [2:0] size;
      logic [7:0] len;
      logic       fixed;
      logic       wrap;
   } cmd_t;

   typedef struct packed {
      logic [DWO-1:0] data;
      logic [IDW-1:0] id;
      logic [1:0]     resp;
      logic [UW-1:0]  user;
      logic           last;
   } wide_t;

   typedef struct packed {
      logic [DWI-1:0] data;
      logic [IDW-1:0] id;
      logic [1:0]     resp;
      logic [UW-1:0]  user;
      logic           last;
   } nb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   caxi4interconnect_dwc_upconv_rchan_extractor_if #(
      .DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO), .ID_WIDTH(IDW), .USER_WIDTH(UW)
   ) bus ();

   caxi4interconnect_dwc_upconv_rchan_extractor #(
      .DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO), .ID_WIDTH(IDW), .USER_WIDTH(UW)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   cmd_t  cq[$];
   wide_t sq[$];
   nb_t   eq[$];
   int    n_vec = 0;
   int    n_fail = 0;
   int    n_rx = 0;
   int    n_spop = 0;
   int    n_spush = 0;
   int    last_cycles = 0;
   int    rdy_mode = 0;
   bit    gaps = 1'b0;
   bit    s_popped = 1'b0;
   bit    exp_err = 1'b0;
   logic [DWO-1:0] d0 = 64'h22222222_11111111;
   logic [DWO-1:0] d1 = 64'h44444444_33333333;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      if (!bus.s_rvalid || s_popped) begin
         bus.s_rvalid = (sq.size() > 0) && (!gaps || ($urandom_range(3) != 0));
      end
      if (sq.size() > 0) begin
         {bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_ruser, bus.s_rlast} = sq[0];
      end else begin
         {bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_ruser, bus.s_rlast} = '0;
      end
      s_popped = 1'b0;
      bus.cmd_fifo_empty = (cq.size() == 0);
      if (cq.size() > 0) begin
         {bus.cmd_addr, bus.cmd_size, bus.cmd_len, bus.cmd_fixed, bus.cmd_wrap} = cq[0];
      end
      if (rdy_mode == 0)      bus.m_rready = 1'b1;
      else if (rdy_mode == 1) bus.m_rready = 1'($urandom_range(1));
      else                    bus.m_rready = 1'b0;
   endtask

   task automatic step();
      nb_t obs;
      @(negedge clk);
      if (bus.m_rvalid && bus.m_rready) begin
         obs = {bus.m_rdata, bus.m_rid, bus.m_rresp, bus.m_ruser, bus.m_rlast};
         if (eq.size() > 0) begin
            chk("rbeat", 64'(obs), 64'(eq[0]));
            eq.delete(0);
            n_rx++;
         end else begin
            chk("extra_beat", 64'(bus.m_rvalid), 64'd0);
         end
      end
      if (bus.s_rvalid && bus.s_rready && sq.size() > 0) begin
         sq.delete(0);
         s_popped = 1'b1;
         n_spop++;
      end
      if (bus.cmd_fifo_rd_en && cq.size() > 0) cq.delete(0);
      @(posedge clk);
      #1;
      drive();
   endtask

   // Reference: AXI beat addresses, then the wide beat each narrow beat draws from.
   task automatic push_burst(input cmd_t c, input bit directed, input bit early);
      int    addr[$];
      bit    popq[$];
      wide_t w[$];
      wide_t cw;
      nb_t   e;
      int    sa, incr, bnd, base, a, nw, k, lane;
      sa = int'(c.addr);
      incr = 1 << c.size;
      for (int i = 0; i <= int'(c.len); i++) begin
         if (c.fixed || i == 0) a = sa;
         else if (c.wrap) begin
            bnd  = (int'(c.len) + 1) * incr;
            base = sa - (sa % bnd);
            a    = base + ((sa - base + i * incr) % bnd);
         end else a = (sa & ~(incr - 1)) + i * incr;
         addr.push_back(a % 64);
      end
      nw = 0;
      for (int i = 0; i <= int'(c.len); i++) begin
         if (i == int'(c.len) || c.fixed) popq.push_back(1'b1);
         else popq.push_back(((addr[i+1] / OBY) != (addr[i] / OBY)) ||
                             ((addr[i+1] % OBY) <= (addr[i] % OBY)));
         if (popq[i]) nw++;
      end
      for (int j = 0; j < nw; j++) begin
         if (directed) cw.data = (j == 0) ? d0 : d1;
         else cw.data = {$urandom, $urandom};
         cw.id   = IDW'($urandom);
         cw.resp = 2'($urandom);
         cw.user = UW'($urandom);
         cw.last = (j == nw - 1) || (early && j == 0);
         w.push_back(cw);
         sq.push_back(cw);
      end
      k = 0;
      for (int i = 0; i <= int'(c.len); i++) begin
         cw     = w[k];
         lane   = (addr[i] % OBY) / IBY;
         e.data = cw.data[lane*DWI +: DWI];
         e.id   = cw.id;
         e.resp = cw.resp;
         e.user = cw.user;
         e.last = (i == int'(c.len));
         eq.push_back(e);
         if (popq[i]) k++;
      end
      n_spush += nw;
      cq.push_back(c);
      drive();
   endtask

   task automatic run_done(input string tag);
      int cyc = 0;
      while ((eq.size() > 0 || cq.size() > 0) && cyc < 3000) begin
         step();
         cyc++;
      end
      chk({tag, "_timeout"}, 64'(eq.size()), 64'd0);
      chk({tag, "_sbeats"}, 64'(n_spop), 64'(n_spush));
      chk({tag, "_err"}, 64'(bus.err_early_last), 64'(exp_err));
      last_cycles = cyc;
   endtask

   task automatic run_until(input int n);
      int cyc = 0;
      n_rx = 0;
      while (n_rx < n && cyc < 200) begin
         step();
         cyc++;
      end
      chk("run_until_timeout", 64'(n_rx), 64'(n));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ctl"}, 64'({bus.m_rvalid, bus.s_rready, bus.cmd_fifo_rd_en,
                               bus.err_early_last, bus.m_rlast}), 64'd0);
      chk({tag, "_data"}, 64'({bus.m_rdata, bus.m_rid, bus.m_rresp, bus.m_ruser}), 64'd0);
   endtask

   initial begin
      cmd_t c1, c;
      int   t;
      bus.cmd_fifo_empty = 1'b1;
      {bus.cmd_addr, bus.cmd_size, bus.cmd_len, bus.cmd_fixed, bus.cmd_wrap} = '0;
      {bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_ruser, bus.s_rlast} = '0;
      bus.s_rvalid = 1'b0;
      bus.m_rready = 1'b1;
      c1 = '{addr: 6'h00, size: 3'd2, len: 8'd3, fixed: 1'b0, wrap: 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("post_reset");
      @(posedge clk);
      #1;

      // Two back-to-back bursts: one-cycle latency, one beat/cycle, one IDLE gap.
      push_burst(c1, 1'b1, 1'b0);
      push_burst(c1, 1'b1, 1'b0);
      run_done("incr_a0");
      chk("throughput_cycles", 64'(last_cycles), 64'd11);

      push_burst('{addr: 6'h04, size: 3'd2, len: 8'd2, fixed: 1'b0, wrap: 1'b0}, 1'b1, 1'b0);
      run_done("incr_a4");
      push_burst('{addr: 6'h01, size: 3'd0, len: 8'd3, fixed: 1'b0, wrap: 1'b0}, 1'b1, 1'b0);
      run_done("incr_byte");
      chk("incr_byte_one_wide", 64'(n_spush), 64'(n_spop));
      push_burst('{addr: 6'h08, size: 3'd2, len: 8'd3, fixed: 1'b0, wrap: 1'b1}, 1'b1, 1'b0);
      run_done("wrap_a8");

      // Backpressure after beat 1 is taken: beat 2 must hold with no slave pop.
      push_burst(c1, 1'b1, 1'b0);
      run_until(1);
      rdy_mode = 2;
      bus.m_rready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_data", 64'(bus.m_rdata), 64'h22222222);
         chk("stall_vld_srdy", 64'({bus.m_rvalid, bus.s_rready}), 64'b10);
         @(posedge clk);
         #1;
      end
      rdy_mode = 0;
      bus.m_rready = 1'b1;
      run_done("stall");

      push_burst(c1, 1'b1, 1'b1);
      exp_err = 1'b1;
      run_done("early_last");

      gaps = 1'b1;
      rdy_mode = 1;
      for (int n = 0; n < 40; n++) begin
         t = $urandom_range(2);
         c.size  = 3'($urandom_range(2));
         c.fixed = (t == 1);
         c.wrap  = (t == 2);
         if (t == 2) begin
            c.len  = 8'((2 << $urandom_range(3)) - 1);
            c.addr = 6'($urandom_range(63)) & ~6'((7'd1 << c.size) - 7'd1);
         end else begin
            c.len  = 8'($urandom_range(15));
            c.addr = 6'($urandom_range(63));
         end
         push_burst(c, 1'b0, 1'b0);
         if (n % 3 == 0) run_done("random");
      end
      run_done("random_tail");
      gaps = 1'b0;
      rdy_mode = 0;

      // Reset while beat 2 sits in the output register; upstream is flushed too.
      push_burst(c1, 1'b1, 1'b0);
      run_until(1);
      rst = 1'b1;
      cq.delete();
      sq.delete();
      eq.delete();
      bus.s_rvalid = 1'b0;
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid_reset");
      exp_err = 1'b0;
      n_spop = 0;
      n_spush = 0;
      @(posedge clk);
      #1;
      push_burst(c1, 1'b1, 1'b0);
      run_done("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/caxi4interconnect_dwc_upconv_rchan_extractor.md
# caxi4interconnect_dwc_upconv_rchan_extractor

Read-data extractor for the up-converting data-width converter. It takes wide read beats from the slave-side R channel and returns them to the narrow master as a sequence of DATA_WIDTH_IN beats, selecting byte lanes from the current beat address. Per-burst decode fields (start address, size, length, burst type) come from a show-ahead command FIFO written by the AR-side converter. It is the read-direction counterpart of the write-channel hold-register/packer path.

## Interface
- DATA_WIDTH_IN, 32, master-side (narrow) data width; 8..512, power of two.
- DATA_WIDTH_OUT, 64, slave-side (wide) data width; power of two, greater than DATA_WIDTH_IN, at most 512.
- ID_WIDTH, 4, RID width.
- USER_WIDTH, 1, RUSER width.

Ports:
- clk  in  1  sole clock; everything is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_fifo_empty  in  1  command FIFO empty; the cmd_* fields are valid whenever this is low (show-ahead FIFO).
- cmd_fifo_rd_en  out  1  pops one command.
- cmd_addr  in  6  start address, low bits.
- cmd_size  in  3  master ARSIZE; must be ≤ log2(DATA_WIDTH_IN/8).
- cmd_len  in  8  master ARLEN (beats − 1).
- cmd_fixed, cmd_wrap  in  1 each  burst type flags; both low means INCR.
- s_rdata  in  DATA_WIDTH_OUT  wide read data.
- s_rid  in  ID_WIDTH  slave read ID.
- s_rresp  in  2  slave read response.
- s_ruser  in  USER_WIDTH  slave read user field.
- s_rlast  in  1  slave last beat.
- s_rvalid  in  1  slave beat valid.
- s_rready  out  1  slave beat ready.
- m_rdata  out  DATA_WIDTH_IN  narrow read data.
- m_rid  out  ID_WIDTH  master read ID.
- m_rresp  out  2  master read response.
- m_ruser  out  USER_WIDTH  master read user field.
- m_rlast  out  1  master last beat.
- m_rvalid  out  1  master beat valid.
- m_rready  in  1  master beat ready.
- err_early_last  out  1  sticky flag: s_rlast was popped before the final master beat.

## Operation
- States: IDLE and ACTIVE.
- IDLE:
  - cmd_fifo_rd_en = !cmd_fifo_empty (combinational).
  - On a pop, capture cur_addr, size, remaining = cmd_len, fixed and wrap, then move to ACTIVE.
- ACTIVE:
  - load = s_rvalid && (!m_rvalid || m_rready).
  - On load, the output register takes:
    - m_rdata = IN-width chunk of s_rdata at lane index cur_addr[log2(OB)−1:log2(IB)], where OB/IB are the output/input byte widths;
    - m_rid/m_rresp/m_ruser from the s_r* inputs;
    - m_rlast = (remaining == 0).
- Pop decision: s_rready = load && pop. pop is true when any of the following holds:
  - remaining == 0;
  - cmd_fixed;
  - next_addr[5:log2(OB)] ≠ cur_addr[5:log2(OB)];
  - next offset ≤ current offset (wrap-around).
- Address update, with incr = 1<<size, all arithmetic mod 64 on 6 bits:
  - INCR: next = (cur_addr & ~(incr−1)) + incr.
  - WRAP: wmask = ((cmd_len+1)<<size) − 1; next = (cur & ~wmask) | ((cur+incr) & wmask).
  - FIXED: next = cur_addr.
- Each load decrements remaining. The load with remaining == 0 returns the FSM to IDLE.
- m_rlast comes only from the beat counter, never from s_rlast. If s_rlast is popped while remaining ≠ 0, err_early_last is set; it clears only on rst.
- m_rvalid clears on m_rready when no new load happens in the same cycle.

## Timing
- Reset values: all outputs 0, including m_rvalid, s_rready, cmd_fifo_rd_en and err_early_last. State is IDLE, internal registers are 0.
- A reset asserted mid-burst takes effect at the next edge. The in-flight beat and the command are dropped, and the upstream converter is reset together with this block.
- Pipeline timing:
  - Command popped in cycle N; ACTIVE from N+1.
  - A slave beat valid in cycle N+1 appears on m_r* in cycle N+2.
  - Throughput is one narrow beat per cycle under no backpressure.
- Exactly one IDLE cycle separates consecutive bursts. The output register may still hold the last beat during that cycle.
- s_rready depends combinationally on m_rready and s_rvalid; there is no combinational path from s_r* to m_r*.
- Output-register contents stay stable while m_rvalid && !m_rready.

## Structure
- Package caxi4interconnect_dwc_pkg holds:
  - the state enum;
  - localparams IB, OB and LANE_IDX_W;
  - function dwc_next_addr(addr, size, len, fixed, wrap).
- Sub-module caxi4interconnect_dwc_rchan_addr_gen: combinational next_addr and pop computation, which can be shared with the write-side packer.

## Test plan
Default configuration 32/64. Slave beats are D0 = 0x22222222_11111111 and D1 = 0x44444444_33333333.

1. INCR, addr 0x00, size 2, len 3 → m_rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444; s_rready on beats 2 and 4; m_rlast on beat 4 only.
2. INCR, addr 0x04, size 2, len 2 → 0x22222222 (D0 popped), then 0x33333333 and 0x44444444 (D1 popped on last).
3. INCR, addr 0x01, size 0, len 3 → beats 1–3 from the D0 low word with no pop; beat 4 from the D0 high word, popped on last. Exactly one slave beat consumed.
4. WRAP, addr 0x08, size 2, len 3 → addresses 0x08, 0x0C, 0x00, 0x04; data 0x11111111, 0x22222222 (pop), 0x33333333, 0x44444444 (pop).
5. m_rready low for 3 cycles after beat 2 of case 1 → m_rdata holds 0x22222222, s_rready stays 0, no beat lost or duplicated. Also: s_rlast on D0 with len 3 → err_early_last = 1.
6. rst high during beat 2 → next cycle all outputs are 0 and the state is IDLE. The command from case 1 then passes cleanly.
